draw_grid: RTL and testbench

// - Parametrised grid/board plotter for the VGA pixel-plot path: emits one (x, y, colour) pixel per accepted beat

---
 rtl/draw_pkg.sv | 24 ++
 rtl/draw_grid_scan.sv | 73 +++++++
 rtl/draw_grid.sv | 138 +++++++++++++
 tb/tb_draw_grid.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and defaults for the grid plotter: VGA coordinate widths,
// colour constants and the pass state encoding.
package draw_pkg;

  localparam int VGA_XW   = 8;
  localparam int VGA_YW   = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] FG_DEFAULT = 3'b101;
  localparam logic [COLOUR_W-1:0] BG_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HORIZ = 2'd1,
    ST_VERT  = 2'd2,
    ST_DONE  = 2'd3
  } draw_state_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/draw_grid_scan.sv
// Nested step/thickness/line counter (k fastest, then t, then i) shared by both
// drawing phases. It exposes next-cycle values so the top can register pixels.
module draw_grid_scan
  import draw_pkg::*;
#(
  parameter int KN = 106,
  parameter int TN = 2,
  parameter int IN = 9,
  parameter int KW = cnt_w(KN),
  parameter int TW = cnt_w(TN),
  parameter int IW = cnt_w(IN)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [KW-1:0] k_nx_o,
  output logic [TW-1:0] t_nx_o,
  output logic [IW-1:0] i_nx_o,
  output logic          last_o
);

  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic [IW-1:0] i_q, i_d;
  logic          k_last, t_last, i_last;

  assign k_last = (k_q == KW'(KN - 1));
  assign t_last = (t_q == TW'(TN - 1));
  assign i_last = (i_q == IW'(IN - 1));
  assign last_o = k_last && t_last && i_last;

  always_comb begin
    k_d = k_q;
    t_d = t_q;
    i_d = i_q;
    if (clear_i) begin
      k_d = '0;
      t_d = '0;
      i_d = '0;
    end else if (advance_i) begin
      if (!k_last) begin
        k_d = k_q + 1'b1;
      end else begin
        k_d = '0;
        if (!t_last) begin
          t_d = t_q + 1'b1;
        end else begin
          t_d = '0;
          // The final beat wraps everything to zero, ready for the next phase.
          i_d = i_last ? '0 : i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      k_q <= '0;
      t_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      t_q <= t_d;
      i_q <= i_d;
    end
  end

  assign k_nx_o = k_d;
  assign t_nx_o = t_d;
  assign i_nx_o = i_d;

endmodule

// File: rtl/draw_grid.sv
// Grid plotter: streams one pixel per accepted beat covering CELLS+1 horizontal
// then CELLS+1 vertical lines, with start/busy/done and valid/ready handshakes.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; outputs zero
//   ST_HORIZ | emitting horizontal line pixels
//   ST_VERT  | emitting vertical line pixels
//   ST_DONE  | one-cycle done pulse, then back to idle
module draw_grid
  import draw_pkg::*;
#(
  parameter int X0     = 27,
  parameter int Y0     = 10,
  parameter int CELLS  = 8,
  parameter int PITCH  = 13,
  parameter int LINE_W = 2,
  parameter int XW     = VGA_XW,
  parameter int YW     = VGA_YW,
  parameter int CW     = COLOUR_W,
  parameter logic [CW-1:0] FG_COLOUR = FG_DEFAULT,
  parameter logic [CW-1:0] BG_COLOUR = BG_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          erase,
  output logic          busy,
  output logic          done,
  output logic          plot_valid,
  input  logic          plot_ready,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_colour
);

  localparam int L  = CELLS * PITCH + LINE_W;
  localparam int KW = cnt_w(L);
  localparam int TW = cnt_w(LINE_W);
  localparam int IW = cnt_w(CELLS + 1);

  if (X0 + L - 1 >= 2 ** XW) begin : g_bad_x
    $error("draw_grid: board does not fit in the x coordinate range");
  end
  if (Y0 + L - 1 >= 2 ** YW) begin : g_bad_y
    $error("draw_grid: board does not fit in the y coordinate range");
  end
  if (LINE_W < 1 || LINE_W >= PITCH) begin : g_bad_w
    $error("draw_grid: LINE_W must be in 1..PITCH-1");
  end

  draw_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;

  logic          scan_clear, scan_adv, scan_last;
  logic [KW-1:0] k_nx;
  logic [TW-1:0] t_nx;
  logic [IW-1:0] i_nx;

  draw_grid_scan #(
    .KN (L),
    .TN (LINE_W),
    .IN (CELLS + 1),
    .KW (KW),
    .TW (TW),
    .IW (IW)
  ) u_scan (
    .clk       (clk),
    .rst_i     (resetn),
    .clear_i   (scan_clear),
    .advance_i (scan_adv),
    .k_nx_o    (k_nx),
    .t_nx_o    (t_nx),
    .i_nx_o    (i_nx),
    .last_o    (scan_last)
  );

  always_comb begin
    state_d    = state_q;
    scan_clear = 1'b0;
    scan_adv   = 1'b0;
    colour_d   = colour_q;
    x_d        = '0;
    y_d        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HORIZ;
          scan_clear = 1'b1;
          colour_d   = erase ? BG_COLOUR : FG_COLOUR;
        end
      end
      ST_HORIZ: begin
        scan_adv = plot_ready;
        if (plot_ready && scan_last) state_d = ST_VERT;
      end
      ST_VERT: begin
        scan_adv = plot_ready;
        if (plot_ready && scan_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase

    // Pixels are computed from next-cycle counters so plot_* leave a register.
    if (state_d == ST_HORIZ) begin
      x_d = XW'(X0) + XW'(k_nx);
      y_d = YW'(Y0) + YW'(i_nx) * YW'(PITCH) + YW'(t_nx);
    end else if (state_d == ST_VERT) begin
      x_d = XW'(X0) + XW'(i_nx) * XW'(PITCH) + XW'(t_nx);
      y_d = YW'(Y0) + YW'(k_nx);
    end else begin
      colour_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign plot_valid  = (state_q == ST_HORIZ) || (state_q == ST_VERT);
  assign plot_x      = x_q;
  assign plot_y      = y_q;
  assign plot_colour = colour_q;

endmodule

// File: tb/tb_draw_grid.sv
// Bench for draw_grid: default board and a small 4-cell board, compared against
// a pixel list built directly from the line/thickness/step geometry.
module tb_draw_grid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, erase, plot_ready;

  logic       b_busy, b_done, b_valid;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic [2:0] b_col;
  logic       s_busy, s_done, s_valid;
  logic [7:0] s_x;
  logic [6:0] s_y;
  logic [2:0] s_col;

  draw_grid u_big (
    .clk(clk), .resetn(resetn), .start(start), .erase(erase),
    .busy(b_busy), .done(b_done), .plot_valid(b_valid), .plot_ready(plot_ready),
    .plot_x(b_x), .plot_y(b_y), .plot_colour(b_col)
  );

  draw_grid #(.X0(0), .Y0(0), .CELLS(4), .PITCH(8), .LINE_W(1)) u_small (
    .clk(clk), .resetn(resetn), .start(start), .erase(erase),
    .busy(s_busy), .done(s_done), .plot_valid(s_valid), .plot_ready(plot_ready),
    .plot_x(s_x), .plot_y(s_y), .plot_colour(s_col)
  );

  bit         sel;
  logic       m_busy, m_done, m_valid;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_col;
  assign m_busy  = sel ? s_busy  : b_busy;
  assign m_done  = sel ? s_done  : b_done;
  assign m_valid = sel ? s_valid : b_valid;
  assign m_x     = sel ? s_x     : b_x;
  assign m_y     = sel ? s_y     : b_y;
  assign m_col   = sel ? s_col   : b_col;

  int checks = 0;
  int errors = 0;
  int exp_x[$], exp_y[$], cap_x[$], cap_y[$];

  typedef struct {
    bit         sel;
    int         rdy_pct;
    bit         er;
    bit         tog;
    logic [2:0] col;
  } pass_vec_t;

  typedef struct {
    bit sel;
    int idx;
    int x;
    int y;
  } key_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_model(input bit s);
    int x0, y0, c, p, w, l;
    x0 = s ? 0 : 27;
    y0 = s ? 0 : 10;
    c  = s ? 4 : 8;
    p  = s ? 8 : 13;
    w  = s ? 1 : 2;
    l  = c * p + w;
    exp_x.delete();
    exp_y.delete();
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i <= c; i++)
        for (int t = 0; t < w; t++)
          for (int k = 0; k < l; k++) begin
            if (ph == 0) begin
              exp_x.push_back(x0 + k);
              exp_y.push_back(y0 + i * p + t);
            end else begin
              exp_x.push_back(x0 + i * p + t);
              exp_y.push_back(y0 + k);
            end
          end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic run_pass(input bit s, input int rdy_pct, input bit er, input bit tog,
                          input bit hold, input logic [2:0] col);
    int beats, mism, colbad, stallbad, done_at, last_at, n_exp;
    logic was_stall, valid_at_done;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    sel = s;
    build_model(s);
    n_exp = exp_x.size();
    cap_x.delete();
    cap_y.delete();
    beats = 0; mism = 0; colbad = 0; stallbad = 0;
    done_at = -1; last_at = -1; was_stall = 1'b0; valid_at_done = 1'b0;
    hx = '0; hy = '0; hc = '0;
    @(negedge clk);
    start = 1'b1;
    erase = er;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_start", m_busy, 1);
    for (int cyc = 0; cyc < 12000 && done_at < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      plot_ready = ($urandom_range(0, 99) < rdy_pct);
      if (tog) erase = 1'($urandom_range(0, 1));
      if (was_stall && ({m_valid, m_x, m_y, m_col} !== {1'b1, hx, hy, hc})) stallbad++;
      if (m_done) begin
        done_at = cyc;
        valid_at_done = m_valid;
      end else if (m_valid && plot_ready) begin
        cap_x.push_back(int'(m_x));
        cap_y.push_back(int'(m_y));
        if (beats >= n_exp || m_x !== 8'(exp_x[beats]) || m_y !== 7'(exp_y[beats])) mism++;
        if (m_col !== col) colbad++;
        beats++;
        if (beats == n_exp) last_at = cyc;
      end
      was_stall = m_valid && !plot_ready;
      hx = m_x;
      hy = m_y;
      hc = m_col;
    end
    chk("done_seen_in_budget", done_at >= 0, 1);
    chk("beat_count", beats, n_exp);
    chk("pixel_mismatches", mism, 0);
    chk("colour_errors", colbad, 0);
    chk("stall_hold_errors", stallbad, 0);
    chk("done_one_after_last", done_at, last_at + 1);
    chk("valid_low_in_done", valid_at_done, 0);
    @(negedge clk);
    plot_ready = 1'b1;
    chk("busy_low_after_done", m_busy, 0);
    chk("done_single_cycle", m_done, 0);
  endtask

  pass_vec_t pv[6];
  key_t      keys[10];

  initial begin
    int n, nd;
    pv[0] = '{sel: 0, rdy_pct: 100, er: 0, tog: 0, col: 3'b101};
    pv[1] = '{sel: 0, rdy_pct: 50,  er: 0, tog: 0, col: 3'b101};
    pv[2] = '{sel: 0, rdy_pct: 100, er: 1, tog: 1, col: 3'b000};
    pv[3] = '{sel: 0, rdy_pct: 70,  er: 0, tog: 1, col: 3'b101};
    pv[4] = '{sel: 1, rdy_pct: 100, er: 0, tog: 0, col: 3'b101};
    pv[5] = '{sel: 1, rdy_pct: 40,  er: 1, tog: 0, col: 3'b000};
    keys[0] = '{sel: 0, idx: 0,    x: 27,  y: 10};
    keys[1] = '{sel: 0, idx: 105,  x: 132, y: 10};
    keys[2] = '{sel: 0, idx: 106,  x: 27,  y: 11};
    keys[3] = '{sel: 0, idx: 1907, x: 132, y: 115};
    keys[4] = '{sel: 0, idx: 1908, x: 27,  y: 10};
    keys[5] = '{sel: 0, idx: 3815, x: 132, y: 115};
    keys[6] = '{sel: 1, idx: 33,   x: 0,   y: 8};
    keys[7] = '{sel: 1, idx: 164,  x: 32,  y: 32};
    keys[8] = '{sel: 1, idx: 198,  x: 8,   y: 0};
    keys[9] = '{sel: 1, idx: 329,  x: 32,  y: 32};

    // Reset together with start: reset must win.
    resetn = 1'b1; start = 1'b1; erase = 1'b0; plot_ready = 1'b0; sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state_big", {b_busy, b_done, b_valid, b_x, b_y, b_col}, 0);
    chk("reset_state_small", {s_busy, s_done, s_valid, s_x, s_y, s_col}, 0);
    resetn = 1'b0; start = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      plot_ready = 1'b1;
      run_pass(pv[v].sel, pv[v].rdy_pct, pv[v].er, pv[v].tog, 1'b0, pv[v].col);
      for (int j = 0; j < 10; j++) begin
        if (keys[j].sel == pv[v].sel) begin
          if (keys[j].idx < cap_x.size())
            chk($sformatf("key_v%0d_beat%0d", v, keys[j].idx),
                {16'(cap_x[keys[j].idx]), 16'(cap_y[keys[j].idx])},
                {16'(keys[j].x), 16'(keys[j].y)});
          else
            chk($sformatf("key_v%0d_beat%0d_missing", v, keys[j].idx), cap_x.size(), keys[j].idx + 1);
        end
      end
    end

    // Abort mid-pass with reset, then replay from the start.
    do_reset();
    sel = 1'b0;
    plot_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 3000 && n < 1000; c++) begin
      if (m_valid) n++;
      @(negedge clk);
    end
    chk("abort_reached_beat_1000", n, 1000);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_outputs_zero", {m_busy, m_done, m_valid, m_x, m_y, m_col}, 0);
    resetn = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_done || m_busy) nd++;
    end
    chk("abort_no_done_stays_idle", nd, 0);
    run_pass(1'b0, 100, 1'b0, 1'b0, 1'b0, 3'b101);

    // start held for the whole pass: one pass, restart only from idle.
    do_reset();
    run_pass(1'b0, 100, 1'b0, 1'b0, 1'b1, 3'b101);
    @(negedge clk);
    chk("held_start_restarts", m_busy, 1);
    chk("held_start_restart_pixel", {m_valid, m_x, m_y}, {1'b1, 8'd27, 7'd10});
    start = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
